// File: rtl/uart_fifo_param_pkg.sv
// Shared definitions for the parametrised UART FIFO: default geometry and the
// 4-bit Fifo_Status bit masks used across the UART blocks.
package uart_fifo_param_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_ADDR_W = 3;

  localparam logic [3:0] FIFO_FULL   = 4'b1000;
  localparam logic [3:0] FIFO_AFULL  = 4'b0100;
  localparam logic [3:0] FIFO_AEMPTY = 4'b0010;
  localparam logic [3:0] FIFO_EMPTY  = 4'b0001;

  function automatic logic [3:0] pack_status(input logic full, input logic afull,
                                             input logic aempty, input logic empty);
    logic [3:0] s;
    s = 4'b0000;
    if (full)   s = s | FIFO_FULL;
    if (afull)  s = s | FIFO_AFULL;
    if (aempty) s = s | FIFO_AEMPTY;
    if (empty)  s = s | FIFO_EMPTY;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo_param_if.sv
// Bus between a FIFO user (master) and the FIFO itself (slave).
// Write/Read are single-cycle requests sampled at the rising clock edge.
interface uart_fifo_param_if
  import uart_fifo_param_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [WIDTH-1:0]  Data_In;
  logic              Write;
  logic              Read;
  logic [WIDTH-1:0]  Data_Out;
  logic [ADDR_W:0]   AFull_Level;
  logic [ADDR_W:0]   AEmpty_Level;
  logic [3:0]        Fifo_Status;
  logic [ADDR_W:0]   Count;
  logic              Overflow;
  logic              Underflow;
  logic              Clear_Err;

  modport master (
    output Data_In, Write, Read, AFull_Level, AEmpty_Level, Clear_Err,
    input  Data_Out, Fifo_Status, Count, Overflow, Underflow
  );

  modport slave (
    input  Data_In, Write, Read, AFull_Level, AEmpty_Level, Clear_Err,
    output Data_Out, Fifo_Status, Count, Overflow, Underflow
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x WIDTH storage for the UART FIFO: synchronous write, asynchronous read.
// The array has no reset; contents are qualified by the owner's pointers/count.
module uart_fifo_ram
  import uart_fifo_param_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous UART FIFO with occupancy count, run-time thresholds and
// sticky error flags. Define UART_FIFO_FWFT_EN for first-word fall-through output.
module uart_fifo_param
  import uart_fifo_param_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic Clk,
    input  logic Reset,
    uart_fifo_param_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic [WIDTH-1:0]  head;

    logic empty, full, afull, aempty;
    logic rd_acc, wr_acc;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_CNT);
    assign aempty = (count <= bus.AEmpty_Level);
    assign afull  = (count >= bus.AFull_Level);

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
    assign rd_acc = bus.Read && !empty;
    assign wr_acc = bus.Write && (!full || rd_acc);

    uart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (Clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(bus.Data_In),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A fresh error outranks a clear landing in the same cycle.
            if (bus.Write && !wr_acc)  overflow <= 1'b1;
            else if (bus.Clear_Err)    overflow <= 1'b0;

            if (bus.Read && !rd_acc)   underflow <= 1'b1;
            else if (bus.Clear_Err)    underflow <= 1'b0;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is shown directly; an empty FIFO presents zero.
    assign bus.Data_Out = empty ? '0 : head;
`else
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)       data_q <= '0;
        else if (rd_acc) data_q <= head;
    end

    assign bus.Data_Out = data_q;
`endif

    assign bus.Fifo_Status = pack_status(full, afull, aempty, empty);
    assign bus.Count       = count;
    assign bus.Overflow    = overflow;
    assign bus.Underflow   = underflow;

endmodule
